imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Byte lanes per instruction word.
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to an external instruction memory, and holds the
// core in reset until the image is complete.
// Optional checksum stage compiled in with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [P_ADDR_WIDTH-2:0] i_nwords,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte_data,
  output logic                    o_byte_ready,
  output logic                    o_mem_we,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
  output logic                    o_cpu_rst,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int unsigned WI_W = P_ADDR_WIDTH - 2;
  localparam int unsigned NW_W = P_ADDR_WIDTH - 1;
  localparam logic [NW_W-1:0] MAX_WORDS = NW_W'(1 << WI_W);

  state_t                  state_q, state_d;
  logic [NW_W-1:0]         nwords_q;
  logic [WI_W-1:0]         word_idx_q;
  logic [1:0]              byte_cnt_q;
  logic [P_DATA_WIDTH-1:0] word_q;
  logic [P_DATA_WIDTH-1:0] word_next;
  logic [P_ADDR_WIDTH-1:0] addr_q;
  logic [P_DATA_WIDTH-1:0] wdata_q;

  logic            byte_fire;
  logic            last_byte;
  logic            last_word;
  logic            start_ok;
  logic [NW_W-1:0] nwords_clamped;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] acc_q;
  logic [7:0] chk_sum;
`endif

  assign byte_fire      = i_byte_valid & o_byte_ready;
  assign last_byte      = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  assign last_word      = ({1'b0, word_idx_q} == (nwords_q - NW_W'(1)));
  assign start_ok       = i_start & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                                     (state_q == ST_ERR));
  assign nwords_clamped = (i_nwords > MAX_WORDS) ? MAX_WORDS : i_nwords;
  assign o_mem_addr     = addr_q;
  assign o_mem_wdata    = wdata_q;

  // Current word with the incoming byte merged into its lane.
  always_comb begin
    word_next = word_q;
    word_next[{byte_cnt_q, 3'b000} +: 8] = i_byte_data;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_sum = acc_q + i_byte_data;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    o_cpu_rst    = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        o_done    = (state_q == ST_DONE);
        o_cpu_rst = (state_q != ST_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        o_err     = (state_q == ST_ERR);
`endif
        if (i_start) begin
          state_d = (i_nwords == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (byte_fire && last_byte) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_mem_we = 1'b1;
        o_busy   = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_CHK: begin
        o_busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        o_byte_ready = 1'b1;
        if (byte_fire) begin
          state_d = (chk_sum == 8'h00) ? ST_DONE : ST_ERR;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, word assembly and write-port holding registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      nwords_q   <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        nwords_q   <= nwords_clamped;
        word_idx_q <= '0;
        byte_cnt_q <= '0;
      end
      if (state_q == ST_RECV && byte_fire) begin
        word_q     <= word_next;
        byte_cnt_q <= byte_cnt_q + 2'd1;
        // Address/data registers load on the 4th byte so they are valid for
        // the whole WRITE cycle and hold afterwards.
        if (last_byte) begin
          addr_q  <= {word_idx_q, 2'b00};
          wdata_q <= word_next;
        end
      end
      if (state_q == ST_WRITE && !last_word) begin
        word_idx_q <= word_idx_q + WI_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running modulo-256 sum of all accepted data bytes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
    end else if (start_ok) begin
      acc_q <= '0;
    end else if (state_q == ST_RECV && byte_fire) begin
      acc_q <= acc_q + i_byte_data;
    end
  end
`endif

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a queue-based reference model.
// Honours `define IMEM_LOADER_CHECKSUM_EN for the checksum byte and tests.
module tb_imem_loader;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int MAXW   = 1 << (AW - 2);
  localparam int BUDGET = 20000;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW-2:0] i_nwords;
  logic          i_byte_valid;
  logic [7:0]    i_byte_data;
  logic          o_byte_ready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_cpu_rst;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  always #5 i_clk = ~i_clk;

  imem_loader #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_nwords     (i_nwords),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_rst    (o_cpu_rst),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stream to send and observations from the last load.
  logic [7:0]    tx_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            lat_errs;
  int            done_iter;
  int            consumed;
  bit            timed_out;
  bit            end_done, end_err, end_cpu_rst;
  logic [AW-1:0] end_addr;
  logic [DW-1:0] end_wdata;

  function automatic int words_of(input int nw);
    return (nw > MAXW) ? MAXW : nw;
  endfunction

  function automatic logic [DW-1:0] exp_word(input int k);
    return {tx_q[4*k+3], tx_q[4*k+2], tx_q[4*k+1], tx_q[4*k]};
  endfunction

  // Append the byte that makes the data-byte sum wrap to zero.
  task automatic add_checksum(input int ndata);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < ndata; i++) s = s + tx_q[i];
    tx_q.push_back(8'h00 - s);
`else
    if (ndata < 0) tx_q.delete();
`endif
  endtask

  task automatic build_random(input int nw);
    tx_q.delete();
    for (int i = 0; i < 4 * words_of(nw); i++) tx_q.push_back(8'($urandom));
    if (nw > 0) add_checksum(4 * words_of(nw));
  endtask

  // Issue a load and stream tx_q; mode 0 = always valid, 1 = alternate,
  // 2 = random. glitch_iter pulses i_start (nwords 0) at that iteration.
  task automatic drive_load(input int nw, input int mode, input int glitch_iter);
    int idx;
    int ndata;
    int iter;
    bit pend4;
    bit v;
    idx = 0; iter = 0; pend4 = 0;
    ndata = 4 * words_of(nw);
    wr_addr_q.delete();
    wr_data_q.delete();
    lat_errs = 0; done_iter = -1; timed_out = 0;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_nwords = 9'(nw); i_byte_valid = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_mem_we) begin
        wr_addr_q.push_back(o_mem_addr);
        wr_data_q.push_back(o_mem_wdata);
        if (!pend4) lat_errs++;
      end else if (pend4) begin
        lat_errs++;
      end
      pend4 = 0;
      if (i_byte_valid && o_byte_ready) begin
        if (idx < ndata && (idx % 4) == 3) pend4 = 1;
        idx++;
      end
      if (iter > 0 && (o_done || o_err)) begin
        done_iter = iter;
        break;
      end
      if (iter >= BUDGET) begin
        timed_out = 1;
        break;
      end
      @(posedge i_clk); #1;
      iter++;
      i_start = (iter == glitch_iter);
      if (iter == glitch_iter) i_nwords = '0;
      if (idx < tx_q.size()) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = iter[0];
          default: v = 1'($urandom_range(0, 1));
        endcase
      end else begin
        v = 1'b0;
      end
      i_byte_valid = v;
      i_byte_data  = v ? tx_q[idx] : 8'($urandom);
    end
    consumed    = idx;
    end_done    = o_done;
    end_err     = o_err;
    end_cpu_rst = o_cpu_rst;
    end_addr    = o_mem_addr;
    end_wdata   = o_mem_wdata;
    i_byte_valid = 1'b0;
    i_start      = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_nwords = '0; i_byte_valid = 1'b0; i_byte_data = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if ({o_mem_addr, o_mem_wdata, o_done, o_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h wdata=%h done=%b err=%b, required all 0",
               o_mem_addr, o_mem_wdata, o_done, o_err);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_cpu_rst !== 1'b1) begin n_fail++; $display("FAIL idle_cpu_rst c%0d: got %b, required 1", c, o_cpu_rst); end
      n_checks++;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy c%0d: got %b, required 0", c, o_busy); end
      n_checks++;
      if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_we c%0d: got %b, required 0", c, o_mem_we); end
      n_checks++;
      if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready c%0d: got %b, required 0", c, o_byte_ready); end
    end
  endtask

  task automatic check_known_load(input string tag);
    n_checks++;
    if (timed_out || wr_addr_q.size() != 2) begin
      n_fail++;
      $display("FAIL %s_writes: got %0d writes (timeout=%0d), required 2", tag, wr_addr_q.size(), timed_out);
    end else begin
      n_checks++;
      if (wr_addr_q[0] !== 10'h000 || wr_data_q[0] !== 32'h00500013) begin
        n_fail++;
        $display("FAIL %s_w0: got %h/%h, required 000/00500013", tag, wr_addr_q[0], wr_data_q[0]);
      end
      n_checks++;
      if (wr_addr_q[1] !== 10'h004 || wr_data_q[1] !== 32'h00100293) begin
        n_fail++;
        $display("FAIL %s_w1: got %h/%h, required 004/00100293", tag, wr_addr_q[1], wr_data_q[1]);
      end
    end
    n_checks++;
    if (lat_errs != 0) begin n_fail++; $display("FAIL %s_latency: got %0d errors, required 0", tag, lat_errs); end
    n_checks++;
    if (end_done !== 1'b1 || end_cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done=%b cpu_rst=%b, required 1/0", tag, end_done, end_cpu_rst);
    end
    n_checks++;
    if (consumed != tx_q.size()) begin
      n_fail++;
      $display("FAIL %s_consumed: got %0d bytes, required %0d", tag, consumed, tx_q.size());
    end
    n_checks++;
    if (end_addr !== 10'h004 || end_wdata !== 32'h00100293) begin
      n_fail++;
      $display("FAIL %s_hold: got %h/%h, required 004/00100293", tag, end_addr, end_wdata);
    end
  endtask

  task automatic test_directed();
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
    add_checksum(8);
    drive_load(2, 0, -1);
    check_known_load("directed");
  endtask

  task automatic test_stall();
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
    add_checksum(8);
    drive_load(2, 1, -1);
    check_known_load("stall");
  endtask

  task automatic test_reset_mid();
    bit saw_we;
    saw_we = 0;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_nwords = 9'd1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_byte_valid = 1'b1; i_byte_data = 8'hAA;
    @(posedge i_clk); #1;
    i_byte_data = 8'hBB;
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_byte_data = 8'hCC;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_mem_we) saw_we = 1;
      @(posedge i_clk); #1;
      i_byte_data = 8'(c);
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    n_checks++;
    if (saw_we) begin n_fail++; $display("FAIL rstmid_we: got write, required none"); end
    n_checks++;
    if ({o_busy, o_done, o_err, o_byte_ready, o_cpu_rst} !== 5'b00001) begin
      n_fail++;
      $display("FAIL rstmid_idle: busy/done/err/ready/cpu_rst=%b, required 00001",
               {o_busy, o_done, o_err, o_byte_ready, o_cpu_rst});
    end
  endtask

  task automatic test_zero();
    tx_q.delete();
    drive_load(0, 0, -1);
    n_checks++;
    if (done_iter != 1 || end_done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done after %0d cycles, required 1", done_iter);
    end
    n_checks++;
    if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_we: got %0d writes, required 0", wr_addr_q.size()); end
  endtask

  task automatic compare_model(input string tag, input int nw);
    int nwc;
    nwc = words_of(nw);
    n_checks++;
    if (timed_out || wr_addr_q.size() != nwc) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes (timeout=%0d), required %0d", tag, wr_addr_q.size(), timed_out, nwc);
      return;
    end
    for (int k = 0; k < nwc; k++) begin
      n_checks++;
      if (wr_addr_q[k] !== AW'(4 * k) || wr_data_q[k] !== exp_word(k)) begin
        n_fail++;
        $display("FAIL %s_word%0d: got %h/%h, required %h/%h", tag, k, wr_addr_q[k], wr_data_q[k],
                 AW'(4 * k), exp_word(k));
      end
    end
    n_checks++;
    if (lat_errs != 0 || end_done !== 1'b1 || consumed != tx_q.size()) begin
      n_fail++;
      $display("FAIL %s_end: lat_errs=%0d done=%b consumed=%0d, required 0/1/%0d", tag, lat_errs, end_done,
               consumed, tx_q.size());
    end
  endtask

  task automatic test_ignore_start();
    build_random(2);
    drive_load(2, 0, 3);
    compare_model("ignstart", 2);
  endtask

  task automatic test_random();
    int nw;
    for (int t = 0; t < 6; t++) begin
      nw = $urandom_range(1, 6);
      build_random(nw);
      drive_load(nw, 2, -1);
      compare_model("random", nw);
    end
  endtask

  task automatic test_clamp();
    build_random(300);
    drive_load(300, 0, -1);
    compare_model("clamp", 300);
    n_checks++;
    if (end_addr !== 10'h3FC) begin n_fail++; $display("FAIL clamp_last_addr: got %h, required 3fc", end_addr); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
    drive_load(1, 0, -1);
    n_checks++;
    if (timed_out || end_done !== 1'b1 || end_err !== 1'b0 || wr_data_q.size() != 1) begin
      n_fail++;
      $display("FAIL chk_good: done=%b err=%b writes=%0d, required 1/0/1", end_done, end_err, wr_data_q.size());
    end
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    drive_load(1, 0, -1);
    n_checks++;
    if (timed_out || end_err !== 1'b1 || end_done !== 1'b0 || end_cpu_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL chk_bad: err=%b done=%b cpu_rst=%b, required 1/0/1", end_err, end_done, end_cpu_rst);
    end
    // Restart from ERR behaves like IDLE.
    build_random(3);
    drive_load(3, 2, -1);
    compare_model("chk_restart", 3);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_zero();
    test_ignore_start();
    test_random();
    test_clamp();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_loader
